// File: rtl/qed_pkg.sv
// Shared constants and types for the QED instruction-legality filter.
package qed_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_NOP   = 7'b1111111;

  localparam logic [6:0] F7_BASE  = 7'b0000000;
  localparam logic [6:0] F7_ALT   = 7'b0100000;
  localparam logic [6:0] F7_MUL   = 7'b0000001;

  localparam logic [2:0] F3_ADD   = 3'b000;
  localparam logic [2:0] F3_SLL   = 3'b001;
  localparam logic [2:0] F3_WORD  = 3'b010;
  localparam logic [2:0] F3_SR    = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } qed_state_t;

  localparam int unsigned CLS_R  = 0;
  localparam int unsigned CLS_M  = 1;
  localparam int unsigned CLS_I  = 2;
  localparam int unsigned CLS_LS = 3;
  localparam int unsigned CLS_W  = 4;

  // True when a register index lies inside the bounded register file.
  function automatic logic reg_ok(input logic [4:0] idx, input int unsigned limit);
    return 32'(idx) < limit;
  endfunction

endpackage

// File: rtl/qed_inst_filter_if.sv
// Fetch-side handshake and status bundle of the QED instruction filter.
interface qed_inst_filter_if #(
  parameter int unsigned CNT_W = 7
);
  logic              start;
  logic [31:0]       instruction;
  logic              valid_in;
  logic [3:0]        class_en;
  logic              inst_allowed;
  logic              stall_req;
  logic [CNT_W-1:0]  issue_count;
  logic [1:0]        state;
  logic              qed_check;
  logic              violation;

  modport master (
    output start, instruction, valid_in, class_en,
    input  inst_allowed, stall_req, issue_count, state, qed_check, violation
  );

  modport slave (
    input  start, instruction, valid_in, class_en,
    output inst_allowed, stall_req, issue_count, state, qed_check, violation
  );
endinterface

// File: rtl/qed_inst_decode.sv
// Combinational decode of one RV32 word into per-class legality matches.
module qed_inst_decode
  import qed_pkg::*;
#(
  parameter int unsigned REG_LIMIT    = 16,
  parameter int unsigned MEM_IMM_BITS = 10
) (
  input  logic [31:0]      i_instruction,
  output logic [CLS_W-1:0] o_match,
  output logic             o_is_nop
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_rd_ok;
  logic       w_rs1_ok;
  logic       w_rs2_ok;
  logic       w_rs1_zero;
  logic       w_imm_ok;

  assign w_opcode   = i_instruction[6:0];
  assign w_funct3   = i_instruction[14:12];
  assign w_funct7   = i_instruction[31:25];
  assign w_rd_ok    = reg_ok(i_instruction[11:7],  REG_LIMIT);
  assign w_rs1_ok   = reg_ok(i_instruction[19:15], REG_LIMIT);
  assign w_rs2_ok   = reg_ok(i_instruction[24:20], REG_LIMIT);
  assign w_rs1_zero = (i_instruction[19:15] == 5'd0);
  // Memory offsets must stay inside the bounded data memory window.
  assign w_imm_ok   = ((i_instruction[31:20] >> MEM_IMM_BITS) == 12'd0);

  always_comb begin
    o_match  = '0;
    o_is_nop = (w_opcode == OP_NOP);

    if (w_opcode == OP_R && w_rd_ok && w_rs1_ok && w_rs2_ok) begin
      o_match[CLS_R] = (w_funct7 == F7_BASE) ||
                       (w_funct7 == F7_ALT && (w_funct3 == F3_ADD || w_funct3 == F3_SR));
      o_match[CLS_M] = (w_funct7 == F7_MUL) && !w_funct3[2];
    end

    if (w_opcode == OP_I && w_rd_ok && w_rs1_ok) begin
      case (w_funct3)
        F3_SLL:  o_match[CLS_I] = (w_funct7 == F7_BASE);
        F3_SR:   o_match[CLS_I] = (w_funct7 == F7_BASE) || (w_funct7 == F7_ALT);
        default: o_match[CLS_I] = 1'b1;
      endcase
    end

    if (w_funct3 == F3_WORD && w_rs1_zero && w_imm_ok) begin
      o_match[CLS_LS] = (w_opcode == OP_LOAD  && w_rd_ok) ||
                        (w_opcode == OP_STORE && w_rs2_ok);
    end
  end

endmodule

// File: rtl/qed_inst_filter.sv
// Instruction-legality filter and bounded-run sequencer for QED checking.
module qed_inst_filter
  import qed_pkg::*;
#(
  parameter int unsigned REG_LIMIT    = 16,
  parameter int unsigned MEM_IMM_BITS = 10,
  parameter int unsigned MAX_INSTS    = 64,
  parameter int unsigned DRAIN_CYCLES = 32,
  parameter int unsigned CNT_W        = $clog2(MAX_INSTS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  qed_inst_filter_if.slave  bus
);

  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_ISSUE = ST_ISSUE;
  localparam logic [1:0] S_DRAIN = ST_DRAIN;
  localparam logic [1:0] S_DONE  = ST_DONE;

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_issue_cnt;
  logic [DRAIN_W-1:0] r_drain_cnt;
  logic               r_violation;
  logic               r_stall_req;
  logic               r_qed_check;

  logic [1:0]         w_state_nxt;
  logic [CNT_W-1:0]   w_issue_nxt;
  logic [DRAIN_W-1:0] w_drain_nxt;
  logic               w_viol_nxt;
  logic [CLS_W-1:0]   w_match;
  logic               w_is_nop;
  logic               w_legal_op;
  logic               w_allowed;

  qed_inst_decode #(
    .REG_LIMIT    (REG_LIMIT),
    .MEM_IMM_BITS (MEM_IMM_BITS)
  ) u_decode (
    .i_instruction (bus.instruction),
    .o_match       (w_match),
    .o_is_nop      (w_is_nop)
  );

  assign w_legal_op = |(w_match & bus.class_en);
  assign w_allowed  = w_is_nop | ((r_state == S_ISSUE) & w_legal_op);

  // Next-state, counter and sticky-violation logic.
  always_comb begin
    w_state_nxt = r_state;
    w_issue_nxt = r_issue_cnt;
    w_drain_nxt = r_drain_cnt;
    w_viol_nxt  = r_violation | (bus.valid_in & ~w_allowed);

    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_state_nxt = S_ISSUE;
          w_issue_nxt = '0;
          w_drain_nxt = '0;
          w_viol_nxt  = 1'b0;
        end
      end
      S_ISSUE: begin
        if (bus.valid_in && w_legal_op && !w_is_nop) begin
          w_issue_nxt = r_issue_cnt + CNT_W'(1);
          if (w_issue_nxt == CNT_W'(MAX_INSTS)) begin
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (r_drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) begin
          w_state_nxt = S_DONE;
          w_drain_nxt = '0;
        end else begin
          w_drain_nxt = r_drain_cnt + DRAIN_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_issue_cnt <= '0;
      r_drain_cnt <= '0;
      r_violation <= 1'b0;
      r_stall_req <= 1'b0;
      r_qed_check <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_issue_cnt <= w_issue_nxt;
      r_drain_cnt <= w_drain_nxt;
      r_violation <= w_viol_nxt;
      r_stall_req <= (w_state_nxt == S_DRAIN);
      r_qed_check <= (w_state_nxt == S_DONE);
    end
  end

  assign bus.inst_allowed = w_allowed;
  assign bus.stall_req    = r_stall_req;
  assign bus.issue_count  = r_issue_cnt;
  assign bus.state        = r_state;
  assign bus.qed_check    = r_qed_check;
  assign bus.violation    = r_violation;

endmodule

// File: tb/tb_qed_inst_filter.sv
// Scoreboard bench for qed_inst_filter: randomized and directed fetch streams vs a spec-level model.
module tb_qed_inst_filter;

  localparam int unsigned RL    = 16;
  localparam int unsigned MIB   = 10;
  localparam int unsigned MAXI  = 4;
  localparam int unsigned DRN   = 6;
  localparam int unsigned CW    = 3;
  localparam logic [31:0] NOP_W = 32'h0000007F;

  logic clk = 1'b0;
  logic rst = 1'b1;

  qed_inst_filter_if #(.CNT_W(CW)) bus ();

  qed_inst_filter #(
    .REG_LIMIT(RL), .MEM_IMM_BITS(MIB), .MAX_INSTS(MAXI), .DRAIN_CYCLES(DRN), .CNT_W(CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       allowed;
    logic [1:0] state;
    int         cnt;
    logic       viol;
    logic       stall;
    logic       qed;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Spec-level model: phase name, issued count, cycles spent in drain, sticky flag.
  int m_state = 0;
  int m_cnt   = 0;
  int m_drain = 0;
  bit m_viol  = 0;

  task automatic check(input string name, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [6:0] op);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
  endfunction

  function automatic bit model_legal(input logic [31:0] w, input logic [3:0] cen);
    int op  = int'(w[6:0]);
    int f3  = int'(w[14:12]);
    int f7  = int'(w[31:25]);
    int rd  = int'(w[11:7]);
    int rs1 = int'(w[19:15]);
    int rs2 = int'(w[24:20]);
    int imm = int'(w[31:20]);
    bit r = 0, m = 0, i = 0, ls = 0;
    if (op == 'h33 && rd < RL && rs1 < RL && rs2 < RL) begin
      r = (f7 == 0) || (f7 == 'h20 && (f3 == 0 || f3 == 5));
      m = (f7 == 1) && (f3 <= 3);
    end
    if (op == 'h13 && rd < RL && rs1 < RL) begin
      if (f3 == 1)      i = (f7 == 0);
      else if (f3 == 5) i = (f7 == 0) || (f7 == 'h20);
      else              i = 1;
    end
    if (f3 == 2 && rs1 == 0 && imm < (1 << MIB)) begin
      if (op == 'h03 && rd < RL)  ls = 1;
      if (op == 'h23 && rs2 < RL) ls = 1;
    end
    return (r && cen[0]) || (m && cen[1]) || (i && cen[2]) || (ls && cen[3]);
  endfunction

  // Apply one cycle of stimulus, queue what the DUT must show mid-cycle, then advance the model.
  task automatic drive(input bit st, input bit v, input logic [31:0] w, input logic [3:0] cen, input string tag);
    exp_t e;
    bit   nop, legal, allowed;
    @(posedge clk);
    #1;
    bus.start       = st;
    bus.valid_in    = v;
    bus.instruction = w;
    bus.class_en    = cen;
    nop     = (w[6:0] == 7'h7F);
    legal   = model_legal(w, cen);
    allowed = nop || (m_state == 1 && legal);
    e.tag = tag; e.allowed = allowed; e.state = 2'(m_state); e.cnt = m_cnt;
    e.viol = m_viol; e.stall = (m_state == 2); e.qed = (m_state == 3);
    q.push_back(e);
    if (v && !allowed) m_viol = 1;
    case (m_state)
      0, 3: if (st) begin m_state = 1; m_cnt = 0; m_drain = 0; m_viol = 0; end
      1: if (v && legal && !nop) begin
           m_cnt++;
           if (m_cnt == MAXI) m_state = 2;
         end
      default: begin
        m_drain++;
        if (m_drain == DRN) begin m_state = 3; m_drain = 0; end
      end
    endcase
  endtask

  task automatic async_reset_check();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_state", int'(bus.state), 0);
    check("async_rst_count", int'(bus.issue_count), 0);
    check("async_rst_viol", int'(bus.violation), 0);
    check("async_rst_stall", int'(bus.stall_req), 0);
    check("async_rst_qed", int'(bus.qed_check), 0);
    m_state = 0; m_cnt = 0; m_drain = 0; m_viol = 0;
    bus.start = 1'b0; bus.valid_in = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [4:0] rreg();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 15));
  endfunction

  function automatic logic [6:0] rf7();
    int k = $urandom_range(0, 3);
    if (k == 0) return 7'h00;
    if (k == 1) return 7'h20;
    if (k == 2) return 7'h01;
    return 7'($urandom);
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [11:0] imm;
    case ($urandom_range(0, 6))
      0: return enc_r(rf7(), rreg(), rreg(), 3'($urandom), rreg(), 7'h33);
      1: return enc_i({rf7(), 5'($urandom)}, rreg(), 3'($urandom), rreg(), 7'h13);
      2: begin
           imm = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 1023)) : 12'($urandom);
           return enc_i(imm, ($urandom_range(0, 3) == 0) ? rreg() : 5'd0,
                        ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b010, rreg(), 7'h03);
         end
      3: begin
           imm = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 1023)) : 12'($urandom);
           return enc_s(imm, rreg(), ($urandom_range(0, 3) == 0) ? rreg() : 5'd0,
                        ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b010, 7'h23);
         end
      4, 5: return {25'($urandom), 7'h7F};
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every mid-cycle sample consumes the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check({e.tag, ".allowed"}, int'(bus.inst_allowed), int'(e.allowed));
        check({e.tag, ".state"},   int'(bus.state),        int'(e.state));
        check({e.tag, ".count"},   int'(bus.issue_count),  e.cnt);
        check({e.tag, ".viol"},    int'(bus.violation),    int'(e.viol));
        check({e.tag, ".stall"},   int'(bus.stall_req),    int'(e.stall));
        check({e.tag, ".qed"},     int'(bus.qed_check),    int'(e.qed));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] cen;
    bus.start = 1'b0; bus.valid_in = 1'b0; bus.instruction = NOP_W; bus.class_en = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle: ALU op flagged, NOP tolerated.
    drive(0, 1, enc_r(7'h00, 5'd3, 5'd2, 3'd0, 5'd1, 7'h33), 4'hF, "idle_add");
    drive(0, 1, NOP_W, 4'hF, "idle_nop");

    // First run: four ADDIs, drain with one illegal ADD, then done.
    drive(1, 0, NOP_W, 4'hF, "start1");
    for (int k = 0; k < 4; k++)
      drive(0, 1, enc_i(12'(k + 5), 5'd1, 3'd0, 5'd2, 7'h13), 4'hF, "addi");
    for (int k = 0; k < DRN; k++)
      drive(0, 1, (k == 2) ? enc_r(7'h00, 5'd3, 5'd2, 3'd0, 5'd1, 7'h33) : NOP_W, 4'hF, "drain");
    drive(1, 0, NOP_W, 4'hF, "done_start");

    // Class enables and register bound; reset mid-issue at count 2.
    drive(0, 1, enc_r(7'h01, 5'd3, 5'd2, 3'd0, 5'd1, 7'h33), 4'b0101, "mul_off");
    drive(0, 1, enc_r(7'h00, 5'd3, 5'd2, 3'd0, 5'd15, 7'h33), 4'b0101, "add_rd15");
    drive(0, 1, enc_s(12'd4, 5'd5, 5'd0, 3'b010, 7'h23), 4'b0101, "sw_off");
    drive(0, 1, enc_r(7'h00, 5'd3, 5'd2, 3'd0, 5'd16, 7'h33), 4'b0101, "add_rd16");
    drive(0, 1, enc_r(7'h01, 5'd3, 5'd2, 3'd0, 5'd1, 7'h33), 4'b1111, "mul_on");
    drive(0, 0, NOP_W, 4'hF, "pre_rst");
    async_reset_check();

    // Fresh run: memory bounds, then a full issue phase.
    drive(0, 0, NOP_W, 4'hF, "post_rst");
    drive(1, 0, NOP_W, 4'hF, "start2");
    drive(0, 1, enc_i(12'h000, 5'd1, 3'b010, 5'd2, 7'h03), 4'hF, "lw_rs1");
    drive(0, 1, enc_i(12'h400, 5'd0, 3'b010, 5'd2, 7'h03), 4'hF, "lw_400");
    drive(0, 1, enc_i(12'h3FF, 5'd0, 3'b010, 5'd2, 7'h03), 4'hF, "lw_3ff");
    drive(0, 1, enc_s(12'h010, 5'd7, 5'd0, 3'b010, 7'h23), 4'hF, "sw_ok");
    drive(0, 1, enc_i(12'h405, 5'd3, 3'b101, 5'd4, 7'h13), 4'hF, "srai");
    drive(0, 1, enc_r(7'h20, 5'd3, 5'd2, 3'd0, 5'd1, 7'h33), 4'hF, "sub");
    for (int k = 0; k < DRN + 2; k++) drive(0, 1, NOP_W, 4'hF, "drain2");

    // Randomized traffic.
    cen = 4'hF;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 9) == 0) cen = 4'($urandom);
      drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), rand_inst(), cen, "rand");
    end

    for (int k = 0; k < 4 && q.size() > 0; k++) @(negedge clk);
    #1;
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/qed_inst_filter.md
# qed_inst_filter

Parametrised, stateful instruction-legality filter for QED formal runs on the RIDECORE front end. Decodes each fetched 32-bit RISC-V word against a configurable legal set (R/M/I ALU ops and LW/SW restricted to a bounded register file and data memory) and emits a legality flag. The top-level property harness assumes this flag. It also sequences a bounded run: issue up to MAX_INSTS legal instructions, force a NOP-only drain window, then raise the QED check strobe.

## Interface
- REG_LIMIT, default 16: legal register indices are 0..REG_LIMIT-1 (power of two, 2..32).
- MEM_IMM_BITS, default 10: LW/SW immediate must fit in the low MEM_IMM_BITS of imm[11:0]; upper imm bits must be zero.
- MAX_INSTS, default 64: non-NOP instructions accepted per run (≥1).
- DRAIN_CYCLES, default 32: NOP-only cycles after the issue phase (≥1).
- CNT_W, default $clog2(MAX_INSTS+1): issue counter width.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begins a run from IDLE or DONE; ignored in ISSUE and DRAIN.
- instruction  in  32  fetched word.
- valid_in  in  1  instruction is presented this cycle.
- class_en  in  4  enables: [0] base R-ALU, [1] M-ext MUL/MULH/MULHSU/MULHU, [2] I-ALU incl. shifts, [3] LW/SW.
- inst_allowed  out  1  combinational legality of instruction in the current state.
- stall_req  out  1  high in DRAIN; the fetch stage must present NOP.
- issue_count  out  CNT_W  legal non-NOP instructions accepted this run.
- state  out  2  IDLE=0, ISSUE=1, DRAIN=2, DONE=3.
- qed_check  out  1  high throughout DONE.
- violation  out  1  sticky: a valid_in instruction with inst_allowed=0 was seen.

## Operation
- Decode: opcode [6:0], rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20], funct7 [31:25].
- R-ALU (opcode 0110011): ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND with funct7=0; SUB/SRA with funct7=0100000. rd, rs1 and rs2 must all be < REG_LIMIT.
- M-ext: opcode 0110011, funct7=0000001, funct3 000..011, same register rule as R-ALU.
- I-ALU (opcode 0010011): funct3 000/010/011/100/110/111 with any imm. SLLI/SRLI need funct7=0; SRAI needs funct7=0100000. rd and rs1 must be < REG_LIMIT.
- LW (opcode 0000011, funct3 010): rs1=0, rd<REG_LIMIT, instruction[31:20+MEM_IMM_BITS]=0.
- SW (opcode 0100011, funct3 010): rs1=0, rs2<REG_LIMIT, instruction[31:20+MEM_IMM_BITS]=0.
- NOP: opcode 1111111; always legal.
- legal_op = OR of the class matches, each gated by its class_en bit.
- inst_allowed by state: IDLE and DONE → NOP only. ISSUE → legal_op or NOP. DRAIN → NOP only.
- FSM:
  - IDLE -start→ ISSUE.
  - ISSUE: each cycle with valid_in & legal_op & !NOP increments issue_count. When the increment makes issue_count = MAX_INSTS, go to DRAIN next edge. That instruction is counted.
  - DRAIN: the drain counter runs 0..DRAIN_CYCLES-1 and advances every cycle, whether or not valid_in is high. At the last count, go to DONE.
  - DONE -start→ ISSUE.
- On start: clear issue_count, the drain counter and violation.
- violation sets on any cycle with valid_in & !inst_allowed, in any state.
- The start-cycle clear has priority over a violation seen in that same cycle.

## Timing
- Reset values: state=IDLE, issue_count=0, drain counter=0, violation=0, qed_check=0, stall_req=0. inst_allowed follows the IDLE rule.
- inst_allowed has zero latency. It is a pure function of instruction, class_en and the registered state.
- issue_count, state and violation update on the clk edge after the qualifying cycle.
- ISSUE lasts at least MAX_INSTS cycles. DRAIN lasts exactly DRAIN_CYCLES cycles.
- qed_check rises on the first DONE cycle and stays high until start is sampled.
- rst asserted mid-run returns all state to reset values immediately, with no wait for the clock edge.
- Counters never wrap: issue_count saturates at MAX_INSTS because the FSM leaves ISSUE.
- class_en changes take effect in the same cycle.

## Structure
- Package qed_pkg holds:
  - the opcode constants OP_R, OP_I, OP_LOAD, OP_STORE and OP_NOP;
  - the funct7 constants F7_BASE, F7_ALT and F7_MUL;
  - the state enum qed_state_t;
  - the class_en bit indices.
- One sub-module, qed_inst_decode: combinational, parametrised on REG_LIMIT and MEM_IMM_BITS. It outputs the four class-match bits and is_nop.
- The top module holds the FSM, the counters and the violation flag.

## Test plan
- Reset then idle: present ADD x1,x2,x3 with valid_in=1 → inst_allowed=0 and violation=1 on the next edge. A NOP in IDLE → inst_allowed=1.
- start with MAX_INSTS=4: present 4 legal ADDIs → issue_count steps 1..4, then state=DRAIN. Over the next DRAIN_CYCLES cycles stall_req=1, then state=DONE and qed_check=1.
- Register bound with REG_LIMIT=16: ADD with rd=16 → inst_allowed=0. rd=15 → 1. LW with rs1=1 → 0. LW with imm=0x400 and MEM_IMM_BITS=10 → 0. imm=0x3FF → 1.
- class_en=4'b0101: MUL → 0, ADD → 1, SW → 0. Change class_en to 4'b1111 in the same cycle → MUL → 1.
- Drain violation: present ADD in DRAIN → inst_allowed=0 and violation=1. The drain counter still completes on time.
- Assert rst mid-ISSUE with issue_count=2 → state=IDLE and issue_count=0 without a clock edge. A later start runs a full MAX_INSTS issue phase.
